// File: rtl/vline_pair_fetch.sv
// vline_pair_fetch
//   Sequencer in front of the vector data cache operation stage. For each
//   vector load/store it reads one line, or two consecutive lines when the
//   access runs past the end of the first line. It then presents the
//   2*BLOCK_W window to the operation stage. For stores it writes the merged
//   window back, one line at a time. Only one request is in flight at a time.
//
//   Optional feature: define VLINE_SIZE_CHECK_EN to reject requests with
//   size==0 or size>line bytes. A rejected request gets a one-cycle err_o
//   pulse and causes no memory or op traffic. Without the macro err_o stays 0.
//
// Ports
//   clk, rst_n                      clock / async active-low reset
//   req_*                           request in (valid/ready handshake)
//   mem_rd_valid_o/ready_i/line_o   line read request
//   mem_resp_valid_i/data_i         read data, one-cycle pulse
//   op_*_o, op_valid_o/op_ready_i   window + request fields to the op stage
//   op_block_i                      merged window coming back (stores)
//   mem_wr_valid_o/ready_i/line_o/data_o  line write request
//   done_o / err_o                  one-cycle retire / reject pulses
module vline_pair_fetch #(
   parameter int PADDR_W   = 32,
   parameter int ADDR_W    = 5,
   parameter int BLOCK_W   = 256,
   parameter int DATA_W    = 256,
   parameter int SIZE_W    = 6,
   parameter int MICROOP_W = 7
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [PADDR_W-1:0]            req_addr_i,
   input  logic [SIZE_W-1:0]             req_size_i,
   input  logic                          req_store_i,
   input  logic [DATA_W-1:0]             req_data_i,
   input  logic [MICROOP_W-1:0]          req_microop_i,
   output logic                          mem_rd_valid_o,
   input  logic                          mem_rd_ready_i,
   output logic [PADDR_W-ADDR_W-1:0]     mem_rd_line_o,
   input  logic                          mem_resp_valid_i,
   input  logic [BLOCK_W-1:0]            mem_resp_data_i,
   output logic                          op_valid_o,
   input  logic                          op_ready_i,
   output logic [2*BLOCK_W-1:0]          op_block_o,
   output logic [ADDR_W-1:0]             op_offset_o,
   output logic [SIZE_W-1:0]             op_size_o,
   output logic [DATA_W-1:0]             op_data_o,
   output logic [MICROOP_W-1:0]          op_microop_o,
   output logic                          op_multi_o,
   input  logic [2*BLOCK_W-1:0]          op_block_i,
   output logic                          mem_wr_valid_o,
   input  logic                          mem_wr_ready_i,
   output logic [PADDR_W-ADDR_W-1:0]     mem_wr_line_o,
   output logic [BLOCK_W-1:0]            mem_wr_data_o,
   output logic                          done_o,
   output logic                          err_o
);

   localparam int LINE_W = PADDR_W - ADDR_W;
   localparam int SUM_W  = ADDR_W + 2;
   localparam logic [SUM_W-1:0] LINE_BYTES = {2'b01, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {IDLE, RD0, WT0, RD1, WT1, PRES, WB0, WB1} state_t;

   state_t            state;
   logic              store;
   logic [LINE_W-1:0] line0, line1;
   logic [BLOCK_W-1:0] blk_lo, blk_hi;

   logic [SUM_W-1:0]  off_ext, size_ext;
   logic [LINE_W-1:0] line0_next;
   logic              multi_next, size_bad;

   // Two guard bits keep offset+size from overflowing before the compare.
   assign off_ext    = SUM_W'(req_addr_i[ADDR_W-1:0]);
   assign size_ext   = SUM_W'(req_size_i);
   assign multi_next = (off_ext + size_ext) > LINE_BYTES;
   assign line0_next = req_addr_i[PADDR_W-1:ADDR_W];

`ifdef VLINE_SIZE_CHECK_EN
   assign size_bad = (size_ext == '0) || (size_ext > LINE_BYTES);
`else
   assign size_bad = 1'b0;
`endif

   assign op_block_o = {blk_hi, blk_lo};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         req_ready_o    <= 1'b1;
         mem_rd_valid_o <= 1'b0;
         op_valid_o     <= 1'b0;
         mem_wr_valid_o <= 1'b0;
         done_o         <= 1'b0;
         err_o          <= 1'b0;
         mem_rd_line_o  <= '0;
         mem_wr_line_o  <= '0;
         mem_wr_data_o  <= '0;
         op_offset_o    <= '0;
         op_size_o      <= '0;
         op_data_o      <= '0;
         op_microop_o   <= '0;
         op_multi_o     <= 1'b0;
         store          <= 1'b0;
         line0          <= '0;
         line1          <= '0;
         blk_lo         <= '0;
         blk_hi         <= '0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: if (req_valid_i) begin
               if (size_bad) begin
                  err_o <= 1'b1;            // rejected: stay idle and ready
               end else begin
                  req_ready_o    <= 1'b0;
                  op_offset_o    <= req_addr_i[ADDR_W-1:0];
                  op_size_o      <= req_size_i;
                  op_data_o      <= req_data_i;
                  op_microop_o   <= req_microop_i;
                  op_multi_o     <= multi_next;
                  store          <= req_store_i;
                  line0          <= line0_next;
                  line1          <= line0_next + LINE_W'(1);  // wraps past top line
                  blk_lo         <= '0;
                  blk_hi         <= '0;                       // high half 0 when single
                  mem_rd_line_o  <= line0_next;
                  mem_rd_valid_o <= 1'b1;
                  state          <= RD0;
               end
            end
            RD0: if (mem_rd_ready_i) begin
               mem_rd_valid_o <= 1'b0;
               state          <= WT0;
            end
            WT0: if (mem_resp_valid_i) begin
               blk_lo <= mem_resp_data_i;
               if (op_multi_o) begin
                  mem_rd_line_o  <= line1;
                  mem_rd_valid_o <= 1'b1;
                  state          <= RD1;
               end else begin
                  op_valid_o <= 1'b1;
                  state      <= PRES;
               end
            end
            RD1: if (mem_rd_ready_i) begin
               mem_rd_valid_o <= 1'b0;
               state          <= WT1;
            end
            WT1: if (mem_resp_valid_i) begin
               blk_hi     <= mem_resp_data_i;
               op_valid_o <= 1'b1;
               state      <= PRES;
            end
            PRES: if (op_ready_i) begin
               op_valid_o <= 1'b0;
               if (store) begin
                  blk_lo         <= op_block_i[BLOCK_W-1:0];
                  blk_hi         <= op_block_i[2*BLOCK_W-1:BLOCK_W];
                  mem_wr_line_o  <= line0;
                  mem_wr_data_o  <= op_block_i[BLOCK_W-1:0];
                  mem_wr_valid_o <= 1'b1;
                  state          <= WB0;
               end else begin
                  done_o      <= 1'b1;
                  req_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            WB0: if (mem_wr_ready_i) begin
               if (op_multi_o) begin
                  // valid stays high; second line follows back to back
                  mem_wr_line_o <= line1;
                  mem_wr_data_o <= blk_hi;
                  state         <= WB1;
               end else begin
                  mem_wr_valid_o <= 1'b0;
                  done_o         <= 1'b1;
                  req_ready_o    <= 1'b1;
                  state          <= IDLE;
               end
            end
            WB1: if (mem_wr_ready_i) begin
               mem_wr_valid_o <= 1'b0;
               done_o         <= 1'b1;
               req_ready_o    <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vline_pair_fetch.sv
// Scoreboard bench for vline_pair_fetch: a request model pushes expected
// reads, windows, writes and retire pulses; a negedge monitor pops them.
module tb_vline_pair_fetch;
   localparam int PADDR_W = 32, ADDR_W = 5, BLOCK_W = 256, DATA_W = 256;
   localparam int SIZE_W = 6, MICROOP_W = 7;
   localparam int LINE_W = PADDR_W - ADDR_W;
   localparam int LINE_BYTES = 1 << ADDR_W;
`ifdef VLINE_SIZE_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif
   localparam int SNAP_W = 2*BLOCK_W + ADDR_W + SIZE_W + DATA_W + MICROOP_W + 1;

   typedef int unsigned key_t;
   typedef struct {
      logic [2*BLOCK_W-1:0] blk;
      logic [ADDR_W-1:0]    off;
      logic [SIZE_W-1:0]    size;
      logic [DATA_W-1:0]    data;
      logic [MICROOP_W-1:0] uop;
      logic                 multi;
   } op_t;
   typedef struct {
      logic [LINE_W-1:0]  line;
      logic [BLOCK_W-1:0] data;
   } wr_t;

   logic clk, rst_n;
   logic req_valid_i, req_ready_o, req_store_i;
   logic [PADDR_W-1:0] req_addr_i;
   logic [SIZE_W-1:0] req_size_i;
   logic [DATA_W-1:0] req_data_i;
   logic [MICROOP_W-1:0] req_microop_i;
   logic mem_rd_valid_o, mem_rd_ready_i;
   logic [LINE_W-1:0] mem_rd_line_o;
   logic mem_resp_valid_i;
   logic [BLOCK_W-1:0] mem_resp_data_i;
   logic op_valid_o, op_ready_i, op_multi_o;
   logic [2*BLOCK_W-1:0] op_block_o, op_block_i;
   logic [ADDR_W-1:0] op_offset_o;
   logic [SIZE_W-1:0] op_size_o;
   logic [DATA_W-1:0] op_data_o;
   logic [MICROOP_W-1:0] op_microop_o;
   logic mem_wr_valid_o, mem_wr_ready_i;
   logic [LINE_W-1:0] mem_wr_line_o;
   logic [BLOCK_W-1:0] mem_wr_data_o;
   logic done_o, err_o;

   vline_pair_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_size_i(req_size_i), .req_store_i(req_store_i), .req_data_i(req_data_i),
      .req_microop_i(req_microop_i),
      .mem_rd_valid_o(mem_rd_valid_o), .mem_rd_ready_i(mem_rd_ready_i), .mem_rd_line_o(mem_rd_line_o),
      .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
      .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .op_block_o(op_block_o),
      .op_offset_o(op_offset_o), .op_size_o(op_size_o), .op_data_o(op_data_o),
      .op_microop_o(op_microop_o), .op_multi_o(op_multi_o), .op_block_i(op_block_i),
      .mem_wr_valid_o(mem_wr_valid_o), .mem_wr_ready_i(mem_wr_ready_i),
      .mem_wr_line_o(mem_wr_line_o), .mem_wr_data_o(mem_wr_data_o),
      .done_o(done_o), .err_o(err_o)
   );

   int tests = 0, fails = 0, retired = 0, cyc = 0, acc_cyc = 0, mode = 0;
   int rd_hs_cnt = 0;
   logic [LINE_W-1:0] rd_last_line;
   logic [LINE_W-1:0] rd_q[$];
   op_t op_q[$];
   wr_t wr_q[$];
   int done_q[$];
   int err_q[$];
   logic [BLOCK_W-1:0] env_mem [key_t];
   logic [BLOCK_W-1:0] ref_mem [key_t];

   initial begin clk = 0; forever #5 clk = ~clk; end
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [1023:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got unexpected %0h, expected none", name, act);
   endtask

   function automatic logic [BLOCK_W-1:0] init_line(input logic [LINE_W-1:0] l);
      logic [31:0] w;
      w = {5'h15, l} ^ 32'h9E3779B9;
      return {w, ~w, w + 32'd1, w ^ 32'hA5A5A5A5, w * 32'd3, ~(w + 32'd7), w << 1, w >> 3};
   endfunction

   function automatic logic [BLOCK_W-1:0] env_rd(input logic [LINE_W-1:0] l);
      if (env_mem.exists(key_t'(l))) return env_mem[key_t'(l)];
      return init_line(l);
   endfunction

   function automatic logic [BLOCK_W-1:0] ref_rd(input logic [LINE_W-1:0] l);
      if (ref_mem.exists(key_t'(l))) return ref_mem[key_t'(l)];
      return init_line(l);
   endfunction

   // ---------------- memory / ready environment ----------------
   initial begin
      int rd_served = 0, resp_wait = 0, rc = 0, oc = 0, wc = 0;
      bit pend = 0;
      mem_resp_valid_i = 0; mem_resp_data_i = '0;
      mem_rd_ready_i = 0; op_ready_i = 0; mem_wr_ready_i = 0;
      forever begin
         @(posedge clk); #1;
         mem_resp_valid_i = 0;
         mem_resp_data_i  = '0;
         if (!rst_n) begin
            rd_served = rd_hs_cnt; pend = 0; rc = 0; oc = 0; wc = 0;
         end else if (rd_hs_cnt != rd_served) begin
            if (!pend) begin
               pend = 1;
               resp_wait = (mode == 1) ? $urandom_range(0, 2) : 0;
            end
            if (resp_wait == 0) begin
               mem_resp_valid_i = 1;
               mem_resp_data_i  = env_rd(rd_last_line);
               rd_served = rd_hs_cnt;
               pend = 0;
            end else resp_wait--;
         end else if (mode == 1 && $urandom_range(0, 5) == 0) begin
            mem_resp_valid_i = 1;                    // stray pulse, must be ignored
            mem_resp_data_i  = {8{$urandom}};
         end
         case (mode)
            0: begin mem_rd_ready_i = 1; op_ready_i = 1; mem_wr_ready_i = 1; end
            1: begin
               mem_rd_ready_i = ($urandom_range(0, 3) != 0);
               op_ready_i     = ($urandom_range(0, 3) != 0);
               mem_wr_ready_i = ($urandom_range(0, 3) != 0);
            end
            2: begin
               // each valid sees exactly three low-ready cycles first
               if (mem_rd_ready_i) rc = 0;
               if (op_ready_i) oc = 0;
               if (mem_wr_ready_i) wc = 0;
               rc = mem_rd_valid_o ? rc + 1 : 0;
               oc = op_valid_o ? oc + 1 : 0;
               wc = mem_wr_valid_o ? wc + 1 : 0;
               mem_rd_ready_i = (rc > 3);
               op_ready_i     = (oc > 3);
               mem_wr_ready_i = (wc > 3);
            end
            default: begin mem_rd_ready_i = 1; op_ready_i = 1; mem_wr_ready_i = 0; end
         endcase
      end
   end

   // ---------------- monitor ----------------
   initial begin
      bit rd_hold = 0, op_hold = 0, wr_hold = 0;
      logic [LINE_W-1:0] rd_hline;
      logic [SNAP_W-1:0] op_snap, op_now;
      logic [LINE_W+BLOCK_W-1:0] wr_snap;
      op_t e;
      wr_t we;
      int dl;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rd_hold = 0; op_hold = 0; wr_hold = 0;
         end else begin
            if (rd_hold) chk("rd_hold", {mem_rd_valid_o, mem_rd_line_o}, {1'b1, rd_hline});
            rd_hold  = mem_rd_valid_o && !mem_rd_ready_i;
            rd_hline = mem_rd_line_o;
            if (mem_rd_valid_o && mem_rd_ready_i) begin
               if (rd_q.size() == 0) unexpected("rd_extra", mem_rd_line_o);
               else chk("rd_line", mem_rd_line_o, rd_q.pop_front());
               rd_last_line = mem_rd_line_o;
               rd_hs_cnt++;
            end

            op_now = {op_block_o, op_offset_o, op_size_o, op_data_o, op_microop_o, op_multi_o};
            if (op_hold) chk("op_hold", {op_valid_o, op_now}, {1'b1, op_snap});
            op_hold = op_valid_o && !op_ready_i;
            op_snap = op_now;
            if (op_valid_o && op_ready_i) begin
               if (op_q.size() == 0) unexpected("op_extra", op_offset_o);
               else begin
                  e = op_q.pop_front();
                  chk("op_block", op_block_o, e.blk);
                  chk("op_fields", {op_offset_o, op_size_o, op_data_o, op_microop_o, op_multi_o},
                      {e.off, e.size, e.data, e.uop, e.multi});
               end
            end

            if (wr_hold) chk("wr_hold", {mem_wr_valid_o, mem_wr_line_o, mem_wr_data_o}, {1'b1, wr_snap});
            wr_hold = mem_wr_valid_o && !mem_wr_ready_i;
            wr_snap = {mem_wr_line_o, mem_wr_data_o};
            if (mem_wr_valid_o && mem_wr_ready_i) begin
               if (wr_q.size() == 0) unexpected("wr_extra", mem_wr_line_o);
               else begin
                  we = wr_q.pop_front();
                  chk("wr_line", mem_wr_line_o, we.line);
                  chk("wr_data", mem_wr_data_o, we.data);
               end
               env_mem[key_t'(mem_wr_line_o)] = mem_wr_data_o;
            end

            if (done_o) begin
               if (done_q.size() == 0) unexpected("done_extra", done_o);
               else begin
                  dl = done_q.pop_front();
                  if (dl >= 0) chk("done_lat", cyc - acc_cyc, dl);
               end
               retired++;
            end
            if (err_o) begin
               if (err_q.size() == 0) unexpected("err_extra", err_o);
               else begin
                  void'(err_q.pop_front());
                  chk("err_lat", cyc - acc_cyc, 1);
               end
               retired++;
            end
         end
      end
   end

   // ---------------- stimulus + reference model ----------------
   task automatic flush();
      rd_q.delete(); op_q.delete(); wr_q.delete(); done_q.delete(); err_q.delete();
   endtask

   task automatic do_reset();
      #2 rst_n = 0;
      flush();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic issue(input logic [PADDR_W-1:0] addr, input int size, input bit st);
      logic [2*BLOCK_W-1:0] k;
      logic [DATA_W-1:0] d;
      logic [LINE_W-1:0] l0, l1;
      int unsigned off;
      bit multi;
      int w;
      op_t e;
      wr_t we;
      for (int i = 0; i < 16; i++) k[i*32 +: 32] = $urandom;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      @(posedge clk); #1;
      req_valid_i = 1; req_addr_i = addr; req_size_i = SIZE_W'(size); req_store_i = st;
      req_data_i = d; req_microop_i = MICROOP_W'($urandom); op_block_i = k;
      w = 0;
      do begin @(negedge clk); w++; end while (!req_ready_o && w < 20);
      chk("req_ready", req_ready_o, 1);
      acc_cyc = cyc;
      if (req_ready_o) begin
         off = addr % LINE_BYTES;
         if (CHECK_EN && (size == 0 || size > LINE_BYTES)) err_q.push_back(1);
         else begin
            multi = (off + size) > LINE_BYTES;
            l0 = LINE_W'(addr / LINE_BYTES);
            l1 = LINE_W'((longint'(l0) + 1) % (longint'(1) << LINE_W));
            rd_q.push_back(l0);
            if (multi) rd_q.push_back(l1);
            e.blk   = {multi ? ref_rd(l1) : {BLOCK_W{1'b0}}, ref_rd(l0)};
            e.off   = ADDR_W'(off);
            e.size  = SIZE_W'(size);
            e.data  = d;
            e.uop   = req_microop_i;
            e.multi = multi;
            op_q.push_back(e);
            if (st) begin
               we.line = l0; we.data = k[BLOCK_W-1:0]; wr_q.push_back(we);
               ref_mem[key_t'(l0)] = k[BLOCK_W-1:0];
               if (multi) begin
                  we.line = l1; we.data = k[2*BLOCK_W-1:BLOCK_W]; wr_q.push_back(we);
                  ref_mem[key_t'(l1)] = k[2*BLOCK_W-1:BLOCK_W];
               end
            end
            // zero-wait: 4 cycles single load, +2 per extra line, +1 per line written
            done_q.push_back(mode == 0 ? 4 + 2*int'(multi) + (st ? 1 + int'(multi) : 0) : -1);
         end
      end
      @(posedge clk); #1;
      req_valid_i = 0;
   endtask

   task automatic wait_retire();
      int start, w;
      start = retired; w = 0;
      while (retired == start && w < 300) begin @(negedge clk); w++; end
      chk("retire", retired != start, 1);
      if (retired == start) do_reset();
   endtask

   task automatic run(input logic [PADDR_W-1:0] addr, input int size, input bit st);
      issue(addr, size, st);
      wait_retire();
   endtask

   initial begin
      logic [LINE_W-1:0] rl;
      int rs, w;
      bit seen;
      rst_n = 0; req_valid_i = 0; req_addr_i = '0; req_size_i = '0; req_store_i = 0;
      req_data_i = '0; req_microop_i = '0; op_block_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst_req_ready", req_ready_o, 1);
      chk("rst_rd_valid", mem_rd_valid_o, 0);
      chk("rst_op_valid", op_valid_o, 0);
      chk("rst_wr_valid", mem_wr_valid_o, 0);
      chk("rst_done_err", {done_o, err_o}, 0);
      chk("rst_op_block", op_block_o, 0);
      chk("rst_op_regs", {op_offset_o, op_size_o, op_data_o, op_microop_o, op_multi_o}, 0);
      chk("rst_wr_regs", {mem_rd_line_o, mem_wr_line_o, mem_wr_data_o}, 0);

      mode = 0;
      run(32'h0000_0040, 32, 0);
      run(32'h0000_005C, 8, 0);
      run(32'h0000_005C, 8, 1);
      run(32'h0000_005C, 8, 0);
      run(32'hFFFF_FFF8, 16, 0);
      run(32'h0000_0060, 32, 0);
      run(32'h0000_007F, 2, 0);
      run(32'h0000_0080, 4, 1);
      run(32'h0000_00A0, 0, 0);
      run(32'h0000_00C0, 33, 0);
      run(32'hFFFF_FFE4, 20, 1);

      mode = 2;
      run(32'h0000_005C, 8, 0);
      run(32'h0000_003E, 20, 1);
      run(32'h0000_0100, 16, 1);

      mode = 1;
      for (int i = 0; i < 120; i++) begin
         rl = ($urandom_range(0, 9) == 0) ? {LINE_W{1'b1}} : LINE_W'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0: rs = 0;
            1: rs = $urandom_range(LINE_BYTES + 1, 63);
            default: rs = $urandom_range(1, LINE_BYTES);
         endcase
         run({rl, ADDR_W'($urandom_range(0, LINE_BYTES - 1))}, rs, $urandom_range(0, 1) == 1);
      end

      // reset while the first write is stalled
      mode = 3;
      issue(32'h0002_0018, 16, 1);
      w = 0;
      while (!mem_wr_valid_o && w < 50) begin @(negedge clk); w++; end
      chk("wb0_reached", mem_wr_valid_o, 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valids", {mem_rd_valid_o, op_valid_o, mem_wr_valid_o, done_o, err_o}, 0);
      chk("async_rst_ready", req_ready_o, 1);
      flush();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      mode = 0;
      seen = 0;
      repeat (10) begin @(negedge clk); if (mem_wr_valid_o || done_o) seen = 1; end
      chk("no_write_after_rst", seen, 0);
      run(32'h0000_0044, 12, 0);

      repeat (3) @(negedge clk);
      chk("end_queues", {32'(rd_q.size()), 32'(op_q.size()), 32'(wr_q.size()),
                         32'(done_q.size()), 32'(err_q.size())}, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
